// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch sequencer: PC, imem address issue, prefetch FIFO, redirect flush
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        id_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   fetch_pc;
    logic [31:0]   inflight_pc;
    logic [31:0]   addr_q;
    logic          inflight;
    logic [31:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic          pop;
    logic          push;
    logic          issue;
    logic [CW:0]   credits;
    logic [31:0]   redirect_addr;
    logic [31:0]   issue_addr;

    assign if_valid = (count != '0);
    assign if_pc    = if_valid ? pc_mem[rd_ptr]    : 32'h0;
    assign if_instr = if_valid ? instr_mem[rd_ptr] : 32'h0;

    assign pop  = if_valid && id_ready;
    assign push = inflight && !redirect_valid;

    // Slots already promised: buffered + in flight, minus the one decode takes this cycle.
    // pop implies count >= 1, so this never underflows.
    assign credits = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
    assign issue   = redirect_valid || (credits < (CW+1)'(DEPTH));

    assign redirect_addr = {redirect_pc[31:2], 2'b00};
    assign issue_addr    = redirect_valid ? redirect_addr : fetch_pc;
    assign imem_addr     = issue ? issue_addr : addr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= 32'h0;
            addr_q      <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                addr_q      <= issue_addr;
                inflight_pc <= issue_addr;
                fetch_pc    <= issue_addr + 32'd4;
            end
            if (redirect_valid) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + AW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // Storage needs no reset: head outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            pc_mem[wr_ptr]    <= inflight_pc;
            instr_mem[wr_ptr] <= imem_instr;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit against a stream-level reference model
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr = 32'h0;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;

    int          vectors = 0;
    int          errors  = 0;

    // Reference model: the expected instruction stream is simply restart_pc, +4, +8, ...
    logic [31:0] exp_pc;
    logic [31:0] restart_pc;
    int          since;
    logic        hold;
    logic [31:0] hold_pc;
    logic [31:0] hold_instr;

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .id_ready       (id_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return 32'h1000_0000 + (a >> 2);
    endfunction

    // Synchronous instruction memory: data for the sampled address appears after the edge.
    always @(posedge clk) imem_instr <= word(imem_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic restart_model();
        exp_pc     = RESET_PC;
        restart_pc = RESET_PC;
        since      = -1;
        hold       = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        id_ready = 1'b0;
        redirect_valid = 1'b0;
        #1;
        chk("reset_if_valid", 32'(if_valid), 32'd0);
        chk("reset_if_pc", if_pc, 32'h0);
        chk("reset_if_instr", if_instr, 32'h0);
        chk("reset_imem_addr", imem_addr, RESET_PC);
        @(negedge clk);
        rst = 1'b0;
        restart_model();
    endtask

    // One clock cycle with the given inputs; called just after a falling edge.
    task automatic cycle(input logic rdy, input logic rv, input logic [31:0] rpc);
        logic [31:0] ra;
        id_ready = rdy;
        redirect_valid = rv;
        redirect_pc = rpc;
        #1;
        since++;
        if (since == 0)
            chk("first_issue_addr", imem_addr, restart_pc);
        if (hold) begin
            chk("hold_valid", 32'(if_valid), 32'd1);
            chk("hold_pc", if_pc, hold_pc);
            chk("hold_instr", if_instr, hold_instr);
        end
        if (since == 1)
            chk("bubble_after_restart", 32'(if_valid), 32'd0);
        if (since >= 2)
            chk("valid_no_gap", 32'(if_valid), 32'd1);
        if (since == 2)
            chk("restart_head_pc", if_pc, restart_pc);
        if (if_valid && rdy) begin
            chk("xfer_pc", if_pc, exp_pc);
            chk("xfer_instr", if_instr, word(exp_pc));
            exp_pc = exp_pc + 32'd4;
        end
        chk("no_overflow", 32'(dut.count <= DEPTH), 32'd1);
        hold       = if_valid && !rdy && !rv;
        hold_pc    = if_pc;
        hold_instr = if_instr;
        if (rv) begin
            ra = {rpc[31:2], 2'b00};
            chk("redirect_imem_addr", imem_addr, ra);
            exp_pc     = ra;
            restart_pc = ra;
            since      = 0;
        end
        @(posedge clk);
        @(negedge clk);
        redirect_valid = 1'b0;
    endtask

    initial begin
        restart_model();
        repeat (2) @(negedge clk);

        // Reset release, steady stream with decode always ready
        do_reset();
        for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 32'h0);

        // Backpressure from cycle 2 for 10 cycles, then release
        do_reset();
        cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 32'h0);
        chk("stall_issue_stopped", imem_addr, 32'h0000_000C);
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 32'h0);

        // Redirect with 3 buffered entries and one fetch in flight
        do_reset();
        cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 32'h0000_0040);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 32'h0);

        // Redirect in the same cycle that decode takes pc 0x8
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 32'h0000_0080);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 32'h0);

        // Misaligned redirect target
        cycle(1'b1, 1'b1, 32'h0000_0013);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 32'h0);

        // PC wraps past the top of the address space
        cycle(1'b1, 1'b1, 32'hFFFF_FFF8);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 32'h0);

        // Asynchronous reset while buffered entries and a fetch are in flight
        do_reset();
        for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_if_valid", 32'(if_valid), 32'd0);
        chk("async_rst_if_pc", if_pc, 32'h0);
        chk("async_rst_if_instr", if_instr, 32'h0);
        chk("async_rst_imem_addr", imem_addr, RESET_PC);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        restart_model();
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 32'h0);

        // Randomized decode backpressure and redirects
        for (int i = 0; i < 400; i++) begin
            logic        rdy;
            logic        rv;
            logic [31:0] rpc;
            rdy = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 19) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 | 32'($urandom_range(0, 15)) : $urandom;
            cycle(rdy, rv, rpc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
